// File: rtl/interleaver_pkg.sv
// Shared constants and bank-select encoding for the bit-serial block interleaver.
package interleaver_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int COLS_DEF  = 8;
  localparam int BLK_DEF   = ROWS_DEF * COLS_DEF;
  localparam int CNT_W_DEF = $clog2(BLK_DEF);

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/interleaver_bank_ram.sv
// Two-bank bit storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the full flags in the top qualify every read.
module interleaver_bank_ram
  import interleaver_pkg::*;
#(
  parameter int BLK = BLK_DEF,
  parameter int AW  = CNT_W_DEF
) (
  input  logic          clk2,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          wr_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem [0:2*BLK-1];

  always_ff @(posedge clk2) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/interleaver.sv
// Ping-pong block interleaver: bits are written row-major into one bank while
// the other bank is drained column-major, one bit per cycle.
module interleaver
  import interleaver_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic clk2,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  output logic dout,
  output logic dout_valid
);

  localparam int BLK   = ROWS * COLS;
  localparam int CNT_W = $clog2(BLK);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] r_cnt;
  bank_t            w_bank;
  bank_t            r_bank;
  logic [1:0]       full;
  logic [CNT_W-1:0] rd_addr;
  logic             rd_bit;
  logic             w_last;
  logic             rd_go;
  logic             rd_last;

  assign w_last  = din_valid && (w_cnt == LAST);
  // A bank being full is exactly "this bank has a read pending or in progress".
  assign rd_go   = full[r_bank];
  assign rd_last = rd_go && (r_cnt == LAST);

  // Step r reads row r%ROWS, col r/ROWS; row-major storage makes that {row, col}.
  assign rd_addr = {r_cnt[ROW_W-1:0], r_cnt[CNT_W-1:ROW_W]};

  interleaver_bank_ram #(
    .BLK (BLK),
    .AW  (CNT_W)
  ) u_ram (
    .clk2    (clk2),
    .wr_bank (w_bank),
    .wr_addr (w_cnt),
    .wr_data (din),
    .wr_en   (din_valid),
    .rd_bank (r_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_bit)
  );

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt  <= '0;
      w_bank <= BANK0;
    end else if (din_valid) begin
      w_cnt <= w_cnt + ONE;
      if (w_last) begin
        w_bank <= other_bank(w_bank);
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    localparam bank_t THIS_BANK = (gi == 1) ? BANK1 : BANK0;

    always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
        full[gi] <= 1'b0;
      end else if (w_last && (w_bank == THIS_BANK)) begin
        full[gi] <= 1'b1;
      end else if (rd_last && (r_bank == THIS_BANK)) begin
        full[gi] <= 1'b0;
      end
    end
  end

  // Toggling r_bank on the last bit lets the next edge chain straight into
  // the other bank when it is already full, giving gap-free output.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bank     <= BANK0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_go;
      dout       <= rd_go & rd_bit;
      if (rd_go) begin
        r_cnt <= r_cnt + ONE;
        if (rd_last) begin
          r_bank <= other_bank(r_bank);
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaver.sv
// Directed bench for the 8x8 interleaver: output stream is captured with
// timestamps and compared against hand-computed and permuted expectations.
module tb_interleaver;

  localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D1 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D2 = 64'h5A5AC3C30F0FF00F;

  logic clk2;
  logic rst_n;
  logic din;
  logic din_valid;
  logic dout;
  logic dout_valid;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   bad_idle = 0;
  logic out_q[$];
  int   t_q[$];

  interleaver dut (
    .clk2       (clk2),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  always @(posedge clk2) cyc <= cyc + 1;

  always @(negedge clk2) begin
    if (dout_valid === 1'b1) begin
      out_q.push_back(dout);
      t_q.push_back(cyc);
    end else if (dout !== 1'b0) begin
      bad_idle++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [63:0] perm(input logic [63:0] d);
    logic [63:0] o;
    for (int r = 0; r < 64; r++) o[r] = d[(r % 8) * 8 + r / 8];
    return o;
  endfunction

  function automatic logic [63:0] got_block(input int base);
    logic [63:0] v;
    for (int r = 0; r < 64; r++) begin
      if (base + r < out_q.size()) v[r] = out_q[base + r];
      else v[r] = 1'bx;
    end
    return v;
  endfunction

  function automatic int ts(input int i);
    if (i < t_q.size()) return t_q[i];
    return -1;
  endfunction

  task automatic clear_q();
    out_q.delete();
    t_q.delete();
  endtask

  // Entered at a negedge; the following posedge samples the bit.
  task automatic send_bit(input logic b, input logic v);
    din       = b;
    din_valid = v;
    @(negedge clk2);
  endtask

  task automatic idle(input int n);
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (n) @(negedge clk2);
  endtask

  task automatic send_block(input logic [63:0] data, input int gap, output int last_edge);
    for (int i = 0; i < 64; i++) begin
      send_bit(data[i], 1'b1);
      if (gap > 0 && (i + 1) % gap == 0 && i != 63) begin
        repeat (5) send_bit(1'b0, 1'b0);
      end
    end
    last_edge = cyc;
  endtask

  task automatic check_blk(input string tag, input int base, input logic [63:0] exp, input int first_t);
    check({tag, "_bits"}, got_block(base), exp);
    check({tag, "_t0"}, ts(base), first_t);
    check({tag, "_tlast"}, ts(base + 63), first_t + 63);
  endtask

  initial begin
    int le0, le1, le2;
    din       = 1'b0;
    din_valid = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk2);
      din       = 1'b1;
      din_valid = ~din_valid;
      check("rst_hold", {dout, dout_valid}, 2'b00);
    end
    @(negedge clk2);
    din       = 1'b0;
    din_valid = 1'b0;
    rst_n     = 1'b1;

    // one every 8 bits starting at bit 0 -> column 0 all ones -> r=0..7 ones
    clear_q();
    send_block(64'h0101010101010101, 0, le0);
    idle(70);
    check("per_n", out_q.size(), 64);
    check_blk("per", 0, 64'h00000000000000FF, le0 + 1);

    // bit 9 (row1,col1) -> r=9; bit 10 (row1,col2) -> r=17
    clear_q();
    send_block(64'h200, 0, le0);
    idle(70);
    check_blk("ramp9", 0, 64'h200, le0 + 1);
    clear_q();
    send_block(64'h400, 0, le0);
    idle(70);
    check_blk("ramp10", 0, 64'h20000, le0 + 1);

    // three back-to-back blocks -> 192 contiguous outputs
    clear_q();
    send_block(D0, 0, le0);
    send_block(D1, 0, le1);
    send_block(D2, 0, le2);
    idle(70);
    check("str_n", out_q.size(), 192);
    check("str_span", ts(191) - ts(0), 191);
    check_blk("str0", 0, perm(D0), le0 + 1);
    check_blk("str1", 64, perm(D1), le0 + 65);
    check_blk("str2", 128, perm(D2), le0 + 129);

    // 5 idle cycles after every 11 valid bits -> same data, gap between blocks
    clear_q();
    send_block(D0, 11, le0);
    send_block(D1, 11, le1);
    idle(70);
    check("gap_n", out_q.size(), 128);
    check_blk("gap0", 0, perm(D0), le0 + 1);
    check_blk("gap1", 64, perm(D1), le1 + 1);

    // reset in the middle of a read
    clear_q();
    send_block(64'hFFFFFFFFFFFFFFFF, 0, le0);
    idle(10);
    check("pre_rst", {dout, dout_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {dout, dout_valid}, 2'b00);
    idle(3);
    check("rst_held", {dout, dout_valid}, 2'b00);
    rst_n = 1'b1;
    idle(70);
    check("rst_drop_n", out_q.size(), 10);

    // partial block discarded by reset, then a fresh block
    clear_q();
    for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b1);
    idle(2);
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    send_block(D2, 0, le0);
    idle(70);
    check("restart_n", out_q.size(), 64);
    check_blk("restart", 0, perm(D2), le0 + 1);

    check("idle_zero", bad_idle, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
